// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester handshake and FIFO write-port signals around fifo_wr_arbiter.
// master = arbiter side, slave = requesters plus FIFO.
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DW    = 4,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               fifo_we;
  logic [DW-1:0]      fifo_din;
  logic               fifo_re;
  logic               fifo_empty;
  logic               fifo_full;
  logic [IW-1:0]      gnt_id;
  logic [CW-1:0]      credits;
  logic               err;

  modport master (
    input  req_valid, req_data, fifo_re, fifo_empty, fifo_full,
    output req_ready, fifo_we, fifo_din, gnt_id, credits, err
  );

  modport slave (
    output req_valid, req_data, fifo_re, fifo_empty, fifo_full,
    input  req_ready, fifo_we, fifo_din, gnt_id, credits, err
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter owning a FIFO write port.
// A local credit counter replaces the FIFO full flag for flow control.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 4,
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int IW   = $clog2(NREQ)
) (
  input logic              clk,
  input logic              rst_n,
  fifo_wr_arbiter_if.master bus
);

  logic [IW-1:0]   r_rr_ptr;
  logic [CW-1:0]   r_credits;
  logic            r_fifo_we;
  logic [DW-1:0]   r_fifo_din;
  logic [IW-1:0]   r_gnt_id;
  logic            r_err;

  logic            w_found;
  logic [IW-1:0]   w_idx;
  logic [IW-1:0]   w_idx_next;
  logic [NREQ-1:0] w_gnt;
  logic            w_xfer;
  logic            w_rd;
  logic            w_cred_full;
  int              w_j;

  // Search starts at rr_ptr and wraps; the first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = (int'(r_rr_ptr) + k) % NREQ;
      if (!w_found && bus.req_valid[w_j]) begin
        w_found = 1'b1;
        w_idx   = IW'(w_j);
      end
    end
  end

  always_comb begin
    w_gnt = '0;
    if (rst_n && (r_credits != '0) && w_found)
      w_gnt[w_idx] = 1'b1;
  end

  assign w_xfer      = |(w_gnt & bus.req_valid);
  assign w_rd        = bus.fifo_re && !bus.fifo_empty;
  assign w_cred_full = (r_credits == CW'(DEPTH));
  assign w_idx_next  = (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_credits  <= CW'(DEPTH);
      r_fifo_we  <= 1'b0;
      r_fifo_din <= '0;
      r_gnt_id   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_fifo_we <= w_xfer;
      if (w_xfer) begin
        r_fifo_din <= bus.req_data[w_idx*DW +: DW];
        r_gnt_id   <= w_idx;
        r_rr_ptr   <= w_idx_next;
      end
      // A return with nothing outstanding is an error; credits saturate.
      if (w_xfer && !w_rd)
        r_credits <= r_credits - 1'b1;
      else if (w_rd && !w_xfer && !w_cred_full)
        r_credits <= r_credits + 1'b1;
      if ((w_rd && w_cred_full) || (r_fifo_we && bus.fifo_full))
        r_err <= 1'b1;
    end
  end

  assign bus.req_ready = w_gnt;
  assign bus.fifo_we   = r_fifo_we;
  assign bus.fifo_din  = r_fifo_din;
  assign bus.gnt_id    = r_gnt_id;
  assign bus.credits   = r_credits;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: expected FIFO writes are queued by the
// stimulus and matched by a monitor; credits/ready/err are checked inline.
module tb_fifo_wr_arbiter;
  localparam int NREQ  = 4;
  localparam int DW    = 4;
  localparam int DEPTH = 8;

  typedef struct {
    logic [DW-1:0] din;
    logic [1:0]    id;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   n_writes;
  exp_t exp_q[$];

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int din, input int id);
    exp_t e;
    e.din = DW'(din);
    e.id  = 2'(id);
    exp_q.push_back(e);
  endtask

  task automatic do_reads(input int n);
    for (int i = 0; i < n; i++) begin
      bus.fifo_re    = 1'b1;
      bus.fifo_empty = 1'b0;
      tick();
      bus.fifo_re    = 1'b0;
      bus.fifo_empty = 1'b1;
    end
  endtask

  // Write monitor: every registered write must match the next expected word.
  always @(negedge clk) begin
    if (rst_n !== 1'bx && bus.fifo_we === 1'b1) begin
      exp_t e;
      n_writes++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: din %0d id %0d with nothing expected", bus.fifo_din, bus.gnt_id);
      end else begin
        e = exp_q.pop_front();
        if (bus.fifo_din !== e.din || bus.gnt_id !== e.id) begin
          n_fail++;
          $display("FAIL write: got din %0d id %0d expected din %0d id %0d",
                   bus.fifo_din, bus.gnt_id, e.din, e.id);
        end
      end
    end
  end

  initial begin
    n_tests = 0; n_fail = 0; n_writes = 0;
    rst_n          = 1'b0;
    bus.req_valid  = '0;
    bus.req_data   = {4'd4, 4'd3, 4'd2, 4'd1};
    bus.fifo_re    = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_full  = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // idle after reset
    for (int i = 0; i < 5; i++) begin
      chk("idle_ready", int'(bus.req_ready), 0);
      chk("idle_we", int'(bus.fifo_we), 0);
      chk("idle_credits", int'(bus.credits), 8);
      chk("idle_err", int'(bus.err), 0);
      tick();
    end

    // all four valid, no reads: rotate 0..3 twice until credits run out
    bus.req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      push((k % 4) + 1, k % 4);
      #1;
      chk("stream_ready", int'(bus.req_ready), 1 << (k % 4));
      chk("stream_credits", int'(bus.credits), 8 - k);
      tick();
    end
    chk("empty_credits", int'(bus.credits), 0);
    chk("empty_ready", int'(bus.req_ready), 0);
    chk("empty_err", int'(bus.err), 0);
    tick();
    chk("empty_we_drop", int'(bus.fifo_we), 0);

    // one read at zero credits yields exactly one grant
    do_reads(1);
    chk("ret_credits", int'(bus.credits), 1);
    chk("ret_ready", int'(bus.req_ready), 4'b0001);
    push(1, 0);
    tick();
    chk("ret_credits0", int'(bus.credits), 0);
    chk("ret_ready0", int'(bus.req_ready), 0);
    bus.req_valid = '0;

    // simultaneous write and read at credits=3
    do_reads(3);
    chk("c3_credits", int'(bus.credits), 3);
    bus.req_valid  = 4'b0010;
    bus.fifo_re    = 1'b1;
    bus.fifo_empty = 1'b0;
    #1;
    chk("c3_ready", int'(bus.req_ready), 4'b0010);
    push(2, 1);
    tick();
    bus.fifo_re    = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.req_valid  = 4'b0100;
    #1;
    chk("c3_hold", int'(bus.credits), 3);

    // requester 2 alone, first at rr_ptr=2 then at rr_ptr=3
    chk("r2a_ready", int'(bus.req_ready), 4'b0100);
    push(3, 2);
    tick();
    chk("r2b_ready", int'(bus.req_ready), 4'b0100);
    push(3, 2);
    tick();
    chk("r2_credits", int'(bus.credits), 1);

    // wrap: rr_ptr=3 picks 3, then wraps to 0
    bus.req_valid = 4'b1001;
    #1;
    chk("wrap3_ready", int'(bus.req_ready), 4'b1000);
    push(4, 3);
    tick();
    bus.req_valid = '0;
    do_reads(1);
    bus.req_valid = 4'b1001;
    #1;
    chk("wrap0_ready", int'(bus.req_ready), 4'b0001);
    push(1, 0);
    tick();
    bus.req_valid = '0;

    // refill to DEPTH, then one extra read is an underflow
    do_reads(8);
    chk("full_credits", int'(bus.credits), 8);
    chk("full_err0", int'(bus.err), 0);
    do_reads(1);
    chk("under_err", int'(bus.err), 1);
    chk("under_credits", int'(bus.credits), 8);
    tick();
    chk("under_sticky", int'(bus.err), 1);

    // reset clears err; then a write into a full FIFO sets it
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_err", int'(bus.err), 0);
    chk("rst_credits", int'(bus.credits), 8);
    bus.fifo_full = 1'b1;
    bus.req_valid = 4'b0001;
    #1;
    chk("lost_ready", int'(bus.req_ready), 4'b0001);
    push(1, 0);
    tick();
    bus.req_valid = '0;
    chk("lost_err_pre", int'(bus.err), 0);
    tick();
    chk("lost_err", int'(bus.err), 1);
    bus.fifo_full = 1'b0;

    // reset in the middle of a grant stream
    bus.req_valid = 4'hF;
    #1;
    chk("mid_ready1", int'(bus.req_ready), 4'b0010);
    push(2, 1);
    tick();
    chk("mid_ready2", int'(bus.req_ready), 4'b0100);
    push(3, 2);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_ready_rst", int'(bus.req_ready), 0);
    tick();
    chk("mid_we", int'(bus.fifo_we), 0);
    chk("mid_credits", int'(bus.credits), 8);
    chk("mid_err", int'(bus.err), 0);
    rst_n = 1'b1;
    #1;
    chk("mid_rr_reset", int'(bus.req_ready), 4'b0001);
    bus.req_valid = '0;
    tick(); tick();

    chk("queue_drained", exp_q.size(), 0);
    chk("write_count", n_writes, 17);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "timeout");
  end
endmodule
